sha256_nblock: RTL

SHA256_NBLOCK -- requirements
Module: sha256_nblock

---
 rtl/sha256_nblock.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/sha256_nblock.sv
// sha256_nblock: multi-block SHA-256 over a word-addressed memory, one round per clock.
// Build option SHA256_DONE_PULSE_EN: done becomes a one-cycle pulse instead of an idle level.
`default_nettype none
module sha256_nblock #(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  output logic        done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);
  localparam int          NB       = (NUM_OF_WORDS + 18) / 16;
  localparam logic [15:0] C_N      = 16'(NUM_OF_WORDS);
  localparam logic [15:0] C_LAST_T = 16'(16 * NB - 1);
  localparam logic [31:0] C_LEN    = 32'(32 * NUM_OF_WORDS);
  localparam logic [6:0]  C_LAST_B = 7'(NB - 1);

  localparam logic [31:0] C_IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] C_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_COMPUTE = 3'd2,
    S_UPDATE  = 3'd3,
    S_WRITE   = 3'd4
  } state_t;

  function automatic logic [31:0] f_ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t      r_state;
  logic [31:0] r_h [8];
  logic [31:0] r_v [8];
  logic [31:0] r_w [16];
  logic [6:0]  r_blk;
  logic [6:0]  r_cnt;
  logic [15:0] r_msg_base;
  logic [15:0] r_out_base;
`ifdef SHA256_DONE_PULSE_EN
  logic        r_done;
  assign done = r_done;
`else
  assign done = (r_state == S_IDLE);
`endif

  assign mem_clk = clk;

  // Word index t of the word arriving this FETCH cycle (captured one cycle after its address).
  logic [15:0] w_t;
  logic [31:0] w_pad;
  logic [15:0] w_next_base;
  assign w_t         = 16'({r_blk, 4'b0000}) + {9'b0, r_cnt} - 16'd1;
  assign w_pad       = (w_t < C_N)       ? mem_read_data :
                       (w_t == C_N)      ? 32'h80000000  :
                       (w_t == C_LAST_T) ? C_LEN         : 32'h0;
  assign w_next_base = r_msg_base + 16'({r_blk + 7'd1, 4'b0000});

  logic [31:0] w_sched, w_t1, w_t2;
  assign w_sched = (f_ror(r_w[14], 17) ^ f_ror(r_w[14], 19) ^ (r_w[14] >> 10)) + r_w[9]
                 + (f_ror(r_w[1], 7) ^ f_ror(r_w[1], 18) ^ (r_w[1] >> 3)) + r_w[0];
  assign w_t1 = r_v[7] + (f_ror(r_v[4], 6) ^ f_ror(r_v[4], 11) ^ f_ror(r_v[4], 25))
              + ((r_v[4] & r_v[5]) ^ (~r_v[4] & r_v[6])) + C_K[r_cnt[5:0]] + r_w[0];
  assign w_t2 = (f_ror(r_v[0], 2) ^ f_ror(r_v[0], 13) ^ f_ror(r_v[0], 22))
              + ((r_v[0] & r_v[1]) ^ (r_v[0] & r_v[2]) ^ (r_v[1] & r_v[2]));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_blk          <= '0;
      r_cnt          <= '0;
      r_msg_base     <= '0;
      r_out_base     <= '0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      for (int i = 0; i < 8; i++) begin
        r_h[i] <= '0;
        r_v[i] <= '0;
      end
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
`ifdef SHA256_DONE_PULSE_EN
      r_done <= 1'b0;
`endif
    end else begin
`ifdef SHA256_DONE_PULSE_EN
      r_done <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_h        <= C_IV;
            r_v        <= C_IV;
            r_msg_base <= message_addr;
            r_out_base <= output_addr;
            r_blk      <= '0;
            r_cnt      <= '0;
            mem_addr   <= message_addr;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          mem_addr <= mem_addr + 16'd1;
          if (r_cnt != 7'd0) begin
            for (int i = 0; i < 15; i++) r_w[i] <= r_w[i + 1];
            r_w[15] <= w_pad;
          end
          if (r_cnt == 7'd16) begin
            r_cnt   <= '0;
            r_state <= S_COMPUTE;
          end else begin
            r_cnt <= r_cnt + 7'd1;
          end
        end
        S_COMPUTE: begin
          r_v[0] <= w_t1 + w_t2;
          r_v[1] <= r_v[0];
          r_v[2] <= r_v[1];
          r_v[3] <= r_v[2];
          r_v[4] <= r_v[3] + w_t1;
          r_v[5] <= r_v[4];
          r_v[6] <= r_v[5];
          r_v[7] <= r_v[6];
          for (int i = 0; i < 15; i++) r_w[i] <= r_w[i + 1];
          r_w[15] <= w_sched;
          if (r_cnt == 7'd63) begin
            r_cnt   <= '0;
            r_state <= S_UPDATE;
          end else begin
            r_cnt <= r_cnt + 7'd1;
          end
        end
        S_UPDATE: begin
          for (int i = 0; i < 8; i++) begin
            r_h[i] <= r_h[i] + r_v[i];
            r_v[i] <= r_h[i] + r_v[i];
          end
          r_cnt <= '0;
          if (r_blk == C_LAST_B) begin
            mem_we         <= 1'b1;
            mem_addr       <= r_out_base;
            mem_write_data <= r_h[0] + r_v[0];
            r_state        <= S_WRITE;
          end else begin
            r_blk    <= r_blk + 7'd1;
            mem_addr <= w_next_base;
            r_state  <= S_FETCH;
          end
        end
        S_WRITE: begin
          if (r_cnt == 7'd7) begin
            mem_we  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
`ifdef SHA256_DONE_PULSE_EN
            r_done  <= 1'b1;
`endif
          end else begin
            r_cnt          <= r_cnt + 7'd1;
            mem_addr       <= mem_addr + 16'd1;
            mem_write_data <= r_h[3'(r_cnt + 7'd1)];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire
